// File: rtl/sync_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : sync_pkg                                                     |
// | Description : Shared definitions for the sync pulse sequencer: FSM state   |
// |               encoding, default field widths and the minimum-period rule.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sync_pkg;

   // Default widths of the timing fields and the pulse counter
   localparam int unsigned SYNC_TIME_BITS_DEF = 32;
   localparam int unsigned SYNC_CNT_BITS_DEF  = 16;

   // Sequencer state enumeration
   localparam int unsigned SYNC_STATE_BITS = 3;
   localparam logic [2:0] c_ST_IDLE  = 3'd0;
   localparam logic [2:0] c_ST_DELAY = 3'd1;
   localparam logic [2:0] c_ST_PULSE = 3'd2;
   localparam logic [2:0] c_ST_WAIT  = 3'd3;
   localparam logic [2:0] c_ST_TAIL  = 3'd4;

   // Smallest legal pulse spacing: the full pulse plus one low cycle
   function automatic int unsigned sync_min_period(input int unsigned pulse_length);
      return pulse_length + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_pulse_gen                                               |
// | Description : Fixed-length pulse stretcher. A one-cycle request produces a |
// |               registered output pulse PULSE_LENGTH cycles wide, starting   |
// |               one cycle after the request.                                 |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Ports       : clock        in  system clock                                |
// |               reset_n      in  asynchronous active-low reset               |
// |               i_pulse_req  in  one-cycle pulse request                     |
// |               o_sync_out   out stretched sync pulse                        |
// |               o_gen_idle   out no output high cycle remains after this one |
// +----------------------------------------------------------------------------+
module sync_pulse_gen #(
   parameter int unsigned PULSE_LENGTH = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_pulse_req,
   output logic o_sync_out,
   output logic o_gen_idle
);

   localparam int unsigned c_CW = $clog2(PULSE_LENGTH + 1);

   logic            r_sync;
   logic [c_CW-1:0] r_cnt;   // high cycles still to come after the current one

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= 1'b0;
         r_cnt  <= '0;
      end else if (i_pulse_req) begin
         r_sync <= 1'b1;
         r_cnt  <= c_CW'(PULSE_LENGTH - 1);
      end else if (r_cnt != '0) begin
         r_cnt  <= r_cnt - c_CW'(1);
      end else begin
         r_sync <= 1'b0;
      end
   end

   assign o_sync_out = r_sync;
   // Asserted in the last high cycle (or when already low), so the sequencer
   // can retire its burst on the very edge at which the output drops.
   assign o_gen_idle = (r_cnt == '0) && !i_pulse_req;

endmodule
`default_nettype wire

// File: rtl/sync_pulse_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_pulse_sequencer                                         |
// | Description : Programmable sync burst scheduler. After an accepted start   |
// |               it waits cfg_delay cycles, then issues cfg_count pulses of   |
// |               PULSE_LENGTH cycles, spaced cfg_period cycles apart.         |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Ports       : clock        in  system clock                                |
// |               reset_n      in  asynchronous active-low reset               |
// |               start        in  one-cycle start command (IDLE only)         |
// |               abort        in  one-cycle abort command (non-IDLE only)     |
// |               cfg_delay    in  cycles from acceptance to first pulse req   |
// |               cfg_period   in  cycles between pulse requests               |
// |               cfg_count    in  pulses per burst                            |
// |               busy         out high while not IDLE                         |
// |               done         out strobe on normal burst completion           |
// |               aborted      out strobe on accepted abort                    |
// |               cfg_error    out sticky, set by a rejected start             |
// |               pulse_index  out pulses issued in current/last burst         |
// |               sync_out     out sync pulse output                           |
// +----------------------------------------------------------------------------+
module sync_pulse_sequencer
   import sync_pkg::*;
#(
   parameter int unsigned PULSE_LENGTH = 2,
   parameter int unsigned TIME_BITS    = SYNC_TIME_BITS_DEF,
   parameter int unsigned CNT_BITS     = SYNC_CNT_BITS_DEF
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [TIME_BITS-1:0] cfg_delay,
   input  logic [TIME_BITS-1:0] cfg_period,
   input  logic [CNT_BITS-1:0]  cfg_count,
   output logic                 busy,
   output logic                 done,
   output logic                 aborted,
   output logic                 cfg_error,
   output logic [CNT_BITS-1:0]  pulse_index,
   output logic                 sync_out
);

   localparam logic [TIME_BITS-1:0] c_MIN_PERIOD = TIME_BITS'(sync_min_period(PULSE_LENGTH));

   logic [SYNC_STATE_BITS-1:0] r_state;
   logic [TIME_BITS-1:0]       r_timer;
   logic [TIME_BITS-1:0]       r_period;
   logic [CNT_BITS-1:0]        r_count;
   logic [CNT_BITS-1:0]        r_index;
   logic                       r_done;
   logic                       r_aborted;
   logic                       r_cfg_error;

   logic w_cfg_ok;
   logic w_pulse_req;
   logic w_last_pulse;
   logic w_gen_idle;
   logic w_sync;

   assign w_cfg_ok     = (cfg_count != '0) && (cfg_period >= c_MIN_PERIOD);
   assign w_pulse_req  = (r_state == c_ST_PULSE);
   assign w_last_pulse = ((r_index + CNT_BITS'(1)) == r_count);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= c_ST_IDLE;
         r_timer     <= '0;
         r_period    <= '0;
         r_count     <= '0;
         r_index     <= '0;
         r_done      <= 1'b0;
         r_aborted   <= 1'b0;
         r_cfg_error <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_aborted <= 1'b0;

         // Every PULSE cycle issues a request, even one cut short by abort,
         // so the index always counts the pulses that really go out.
         if (w_pulse_req) begin
            r_index <= r_index + CNT_BITS'(1);
         end

         if (r_state == c_ST_IDLE) begin
            // abort is meaningless here; a coincident start still wins
            if (start) begin
               if (w_cfg_ok) begin
                  r_period    <= cfg_period;
                  r_count     <= cfg_count;
                  r_index     <= '0;
                  r_cfg_error <= 1'b0;
                  if (cfg_delay == '0) begin
                     r_state <= c_ST_PULSE;
                     r_timer <= '0;
                  end else begin
                     r_state <= c_ST_DELAY;
                     r_timer <= cfg_delay - TIME_BITS'(1);
                  end
               end else begin
                  r_cfg_error <= 1'b1;
               end
            end
         end else if (abort) begin
            // The pulse generator is left alone so an in-flight pulse
            // finishes at full length.
            r_state   <= c_ST_IDLE;
            r_timer   <= '0;
            r_aborted <= 1'b1;
         end else begin
            case (r_state)
               c_ST_DELAY, c_ST_WAIT: begin
                  if (r_timer == '0) begin
                     r_state <= c_ST_PULSE;
                  end else begin
                     r_timer <= r_timer - TIME_BITS'(1);
                  end
               end
               c_ST_PULSE: begin
                  if (w_last_pulse) begin
                     r_state <= c_ST_TAIL;
                  end else begin
                     // PULSE cycle plus (period-1) WAIT cycles = period
                     r_timer <= r_period - TIME_BITS'(2);
                     r_state <= c_ST_WAIT;
                  end
               end
               c_ST_TAIL: begin
                  if (w_gen_idle) begin
                     r_done  <= 1'b1;
                     r_state <= c_ST_IDLE;
                  end
               end
               default: begin
                  r_state <= c_ST_IDLE;
               end
            endcase
         end
      end
   end

   sync_pulse_gen #(
      .PULSE_LENGTH (PULSE_LENGTH)
   ) u_pulse_gen (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_pulse_req (w_pulse_req),
      .o_sync_out  (w_sync),
      .o_gen_idle  (w_gen_idle)
   );

   assign busy        = (r_state != c_ST_IDLE);
   assign done        = r_done;
   assign aborted     = r_aborted;
   assign cfg_error   = r_cfg_error;
   assign pulse_index = r_index;
   assign sync_out    = w_sync;

endmodule
`default_nettype wire

// File: tb/tb_sync_pulse_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sync_pulse_sequencer                                      |
// | Description : Self-checking bench for sync_pulse_sequencer. A burst-level  |
// |               reference model predicts every output per cycle from the    |
// |               accepted configuration and the abort time.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sync_pulse_sequencer;

   localparam int L    = 2;
   localparam int NMAX = 5000;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] cfg_delay = '0;
   logic [31:0] cfg_period = '0;
   logic [15:0] cfg_count = '0;
   logic        busy, done, aborted, cfg_error, sync_out;
   logic [15:0] pulse_index;

   sync_pulse_sequencer #(
      .PULSE_LENGTH (L),
      .TIME_BITS    (32),
      .CNT_BITS     (16)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .abort       (abort),
      .cfg_delay   (cfg_delay),
      .cfg_period  (cfg_period),
      .cfg_count   (cfg_count),
      .busy        (busy),
      .done        (done),
      .aborted     (aborted),
      .cfg_error   (cfg_error),
      .pulse_index (pulse_index),
      .sync_out    (sync_out)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Burst-level model: one accepted burst described by its timing numbers
   bit exp_sync [NMAX+8];
   bit m_have;
   int m_T, m_P0, m_per, m_cnt, m_A, m_end, m_done, m_abs;
   bit m_err;

   int rises[$];
   int obs_done;
   bit prev_sync;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit m_busy(input int c);
      return m_have && (c > m_T) && (c < m_end);
   endfunction

   // Pulses whose request cycle lies strictly before c and not after the abort
   function automatic int idx_at(input int c);
      int n;
      int na;
      if (!m_have || c <= m_P0) return 0;
      n = (c - 1 - m_P0) / m_per + 1;
      if (n > m_cnt) n = m_cnt;
      if (m_A >= 0) begin
         na = (m_A < m_P0) ? 0 : (m_A - m_P0) / m_per + 1;
         if (na < n) n = na;
      end
      return n;
   endfunction

   task automatic model_reset();
      m_have = 1'b0;
      m_T = 0; m_P0 = 0; m_per = 1; m_cnt = 0;
      m_A = -1; m_end = 0; m_done = -1; m_abs = -1;
      m_err = 1'b0;
      for (int i = cyc; i < NMAX + 8; i++) exp_sync[i] = 1'b0;
   endtask

   // Check cycle `cyc`, drive its inputs, advance the model, move to next cycle
   task automatic step(input bit st, input bit ab, input logic [31:0] d,
                       input logic [31:0] p, input logic [15:0] n);
      check_val("busy",        32'(busy),        32'(m_busy(cyc)));
      check_val("done",        32'(done),        32'(cyc == m_done));
      check_val("aborted",     32'(aborted),     32'(cyc == m_abs));
      check_val("cfg_error",   32'(cfg_error),   32'(m_err));
      check_val("pulse_index", 32'(pulse_index), 32'(idx_at(cyc)));
      check_val("sync_out",    32'(sync_out),    32'(exp_sync[cyc]));
      if (sync_out && !prev_sync) rises.push_back(cyc);
      prev_sync = sync_out;
      if (done) obs_done = cyc;

      start = st; abort = ab; cfg_delay = d; cfg_period = p; cfg_count = n;

      if (m_busy(cyc)) begin
         if (cyc >= m_P0 && ((cyc - m_P0) % m_per) == 0 && ((cyc - m_P0) / m_per) < m_cnt)
            for (int k = 1; k <= L; k++) exp_sync[cyc + k] = 1'b1;
         if (ab) begin
            m_A = cyc; m_abs = cyc + 1; m_end = cyc + 1; m_done = -1;
         end
      end else if (st) begin
         if (n != 0 && p >= 32'(L + 1)) begin
            m_have = 1'b1;
            m_T    = cyc;
            m_P0   = cyc + 1 + int'(d);
            m_per  = int'(p);
            m_cnt  = int'(n);
            m_A    = -1;
            m_end  = m_P0 + (m_cnt - 1) * m_per + 1 + L;
            m_done = m_end;
            m_abs  = -1;
            m_err  = 1'b0;
         end else begin
            m_err = 1'b1;
         end
      end
      @(posedge clock);
      cyc++;
      @(negedge clock);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'($urandom_range(0, 20)), 32'($urandom_range(0, 20)),
           16'($urandom_range(0, 9)));
   endtask

   task automatic rand_step();
      bit st;
      bit ab;
      if (m_busy(cyc)) begin
         st = ($urandom_range(0, 7) == 0);
         ab = ($urandom_range(0, 49) == 0);
      end else begin
         st = ($urandom_range(0, 3) == 0);
         ab = ($urandom_range(0, 5) == 0);
      end
      step(st, ab, 32'($urandom_range(0, 6)), 32'($urandom_range(2, 9)),
           16'($urandom_range(0, 4)));
   endtask

   initial begin
      int t0;
      bit found;
      model_reset();
      obs_done = -1;
      prev_sync = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      cyc = 1;

      // Basic burst: delay 5, period 10, count 3
      rises.delete();
      t0 = cyc;
      step(1'b1, 1'b0, 32'd5, 32'd10, 16'd3);
      repeat (34) idle();
      check_val("basic_rises", 32'(rises.size()), 32'd3);
      if (rises.size() >= 3) begin
         check_val("basic_rise0", 32'(rises[0] - t0), 32'd7);
         check_val("basic_rise1", 32'(rises[1] - t0), 32'd17);
         check_val("basic_rise2", 32'(rises[2] - t0), 32'd27);
      end
      check_val("basic_done_at", 32'(obs_done - t0), 32'd29);
      check_val("basic_index", 32'(pulse_index), 32'd3);

      // Zero delay, minimum period
      rises.delete();
      t0 = cyc;
      step(1'b1, 1'b0, 32'd0, 32'd3, 16'd4);
      repeat (16) idle();
      check_val("zd_rises", 32'(rises.size()), 32'd4);
      if (rises.size() >= 4) begin
         check_val("zd_rise0", 32'(rises[0] - t0), 32'd2);
         check_val("zd_rise3", 32'(rises[3] - t0), 32'd11);
      end

      // Rejected configurations, then a valid start clears the flag
      step(1'b1, 1'b0, 32'd0, 32'd5, 16'd0);
      repeat (3) idle();
      check_val("rej_count_err", 32'(cfg_error), 32'd1);
      step(1'b1, 1'b0, 32'd1, 32'd2, 16'd3);
      repeat (3) idle();
      check_val("rej_period_busy", 32'(busy), 32'd0);
      step(1'b1, 1'b0, 32'd2, 32'd4, 16'd2);
      repeat (15) idle();
      check_val("rej_cleared", 32'(cfg_error), 32'd0);

      // Abort the cycle after the 2nd rising edge
      rises.delete();
      t0 = cyc;
      step(1'b1, 1'b0, 32'd1, 32'd10, 16'd5);
      repeat (13) idle();
      step(1'b0, 1'b1, 32'd1, 32'd10, 16'd5);
      repeat (25) idle();
      check_val("abort_rises", 32'(rises.size()), 32'd2);
      check_val("abort_index", 32'(pulse_index), 32'd2);

      // start+abort together in IDLE, start while busy, cfg changes mid-burst
      step(1'b1, 1'b1, 32'd3, 32'd5, 16'd3);
      repeat (2) idle();
      step(1'b1, 1'b0, 32'd0, 32'd3, 16'd9);
      repeat (25) idle();

      // Randomized traffic
      repeat (3000) rand_step();

      // Reset while sync_out is high
      for (int i = 0; i < 60 && m_busy(cyc); i++) idle();
      step(1'b1, 1'b0, 32'd2, 32'd6, 16'd4);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (exp_sync[cyc]) found = 1'b1;
         else idle();
      end
      check_val("reset_window", 32'(found), 32'd1);
      check_val("pre_reset_sync", 32'(sync_out), 32'd1);
      #2 reset_n = 1'b0;
      start = 1'b0; abort = 1'b0;
      #1;
      check_val("rst_sync", 32'(sync_out), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_index", 32'(pulse_index), 32'd0);
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      cyc++;
      model_reset();
      prev_sync = sync_out;
      step(1'b1, 1'b0, 32'd1, 32'd4, 16'd2);
      repeat (20) idle();
      repeat (200) rand_step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
